acc_stack: RTL and testbench

ACC_STACK -- requirements
Module: acc_stack

---
 rtl/acc_stack_if.sv | 29 ++
 rtl/acc_stack.sv | 106 ++++++++++
 tb/tb_acc_stack.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/acc_stack_if.sv
// Accumulator/stack bus: ALU write, push/pop controls and status.
// Shared by acc_stack (slave) and its driver (master).
interface acc_stack_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH + 1);

    logic             acc_alu_io_rw;
    logic [WIDTH-1:0] alu2acc;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] acc_data;
    logic [LW-1:0]    stk_level;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_err;

    modport master (
        output acc_alu_io_rw, alu2acc, push, pop, err_clr,
        input  acc_data, stk_level, stk_full, stk_empty, stk_err
    );

    modport slave (
        input  acc_alu_io_rw, alu2acc, push, pop, err_clr,
        output acc_data, stk_level, stk_full, stk_empty, stk_err
    );
endinterface

// File: rtl/acc_stack.sv
// Accumulator with a LIFO save stack; push/pop/exchange against ACC.
// Define ACC_STACK_ERR_EN for the sticky overflow/underflow flag.
module acc_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    acc_stack_if.slave   bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [LW-1:0]    lvl_q;
    logic [LW-1:0]    lvl_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             do_xchg;
    logic             err_ev;
    logic             mem_we;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    top_idx;
    logic [WIDTH-1:0] top_val;

    assign full    = (lvl_q == LW'(DEPTH));
    assign empty   = (lvl_q == '0);
    assign do_push = bus.push & ~bus.pop & ~full;
    assign do_pop  = bus.pop & ~bus.push & ~empty;
    assign do_xchg = bus.push & bus.pop & ~empty;
    assign err_ev  = (bus.push & ~bus.pop & full)
                   | (bus.pop & empty);

    assign top_idx = IW'(lvl_q - LW'(1));
    assign top_val = mem[top_idx];

    always_comb begin
        acc_d  = acc_q;
        lvl_d  = lvl_q;
        mem_we = 1'b0;
        wr_idx = IW'(lvl_q);
        unique case (1'b1)
            do_push: begin
                mem_we = 1'b1;
                lvl_d  = lvl_q + LW'(1);
            end
            do_pop: begin
                acc_d = top_val;
                lvl_d = lvl_q - LW'(1);
            end
            do_xchg: begin
                mem_we = 1'b1;
                wr_idx = top_idx;
                acc_d  = top_val;
            end
            default: ;
        endcase
        // ALU write overrides any stack-sourced ACC value
        if (bus.acc_alu_io_rw)
            acc_d = bus.alu2acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            lvl_q <= '0;
        end else begin
            acc_q <= acc_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_idx] <= acc_q;
    end

`ifdef ACC_STACK_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (err_ev)
            err_q <= 1'b1;
        else if (bus.err_clr)
            err_q <= 1'b0;
    end

    assign bus.stk_err = err_q;
`else
    logic unused_err;
    assign unused_err  = err_ev ^ bus.err_clr;
    assign bus.stk_err = 1'b0;
`endif

    assign bus.acc_data  = acc_q;
    assign bus.stk_level = lvl_q;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
endmodule

// File: tb/tb_acc_stack.sv
// Self-checking bench for acc_stack: vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_acc_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
`ifdef ACC_STACK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        rw;
        logic [15:0] din;
        logic        push;
        logic        pop;
        logic        clr;
        logic [15:0] e_acc;
        logic [3:0]  e_lvl;
        logic        e_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [15:0] m_acc;
    logic [15:0] m_stk [$];
    logic        m_err;

    vec_t tbl [17];

    acc_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    acc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic m_reset();
        m_acc = '0;
        m_stk.delete();
        m_err = 1'b0;
    endtask

    task automatic m_step(input logic rw, input logic [15:0] din,
                          input logic pu, input logic po,
                          input logic clr);
        logic        ev;
        logic [15:0] nacc;
        int          n;
        ev   = 1'b0;
        nacc = m_acc;
        n    = m_stk.size();
        if (pu && !po) begin
            if (n == DEPTH) ev = 1'b1;
            else m_stk.push_back(m_acc);
        end else if (po && !pu) begin
            if (n == 0) ev = 1'b1;
            else nacc = m_stk.pop_back();
        end else if (po && pu) begin
            if (n == 0) ev = 1'b1;
            else begin
                nacc = m_stk[n-1];
                m_stk[n-1] = m_acc;
            end
        end
        if (rw) nacc = din;
        m_acc = nacc;
        if (ERR_EN) begin
            if (ev) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
        end
    endtask

    task automatic drive(input logic rw, input logic [15:0] din,
                         input logic pu, input logic po,
                         input logic clr);
        bus.acc_alu_io_rw = rw;
        bus.alu2acc       = din;
        bus.push          = pu;
        bus.pop           = po;
        bus.err_clr       = clr;
        @(posedge clk);
        #1;
        m_step(rw, din, pu, po, clr);
        bus.acc_alu_io_rw = 1'b0;
        bus.push          = 1'b0;
        bus.pop           = 1'b0;
        bus.err_clr       = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        int n;
        n = m_stk.size();
        chk({tag, "_acc"}, 32'(bus.acc_data), 32'(m_acc));
        chk({tag, "_lvl"}, 32'(bus.stk_level), n);
        chk({tag, "_full"}, 32'(bus.stk_full), 32'(n == DEPTH));
        chk({tag, "_empty"}, 32'(bus.stk_empty), 32'(n == 0));
        chk({tag, "_err"}, 32'(bus.stk_err), 32'(m_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m_reset();
        chk("rst_acc", 32'(bus.acc_data), 0);
        chk("rst_empty", 32'(bus.stk_empty), 1);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.acc_alu_io_rw = 1'b0;
        bus.alu2acc       = '0;
        bus.push          = 1'b0;
        bus.pop           = 1'b0;
        bus.err_clr       = 1'b0;
        m_reset();

        tbl[0]  = '{1, 16'h1234, 0, 0, 0, 16'h1234, 0, 0};
        tbl[1]  = '{1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0};
        tbl[2]  = '{1, 16'h0002, 1, 0, 0, 16'h0002, 1, 0};
        tbl[3]  = '{0, 16'h0000, 0, 1, 0, 16'h0001, 0, 0};
        tbl[4]  = '{1, 16'h5555, 0, 0, 0, 16'h5555, 0, 0};
        tbl[5]  = '{0, 16'h0000, 1, 0, 0, 16'h5555, 1, 0};
        tbl[6]  = '{1, 16'hAAAA, 0, 0, 0, 16'hAAAA, 1, 0};
        tbl[7]  = '{0, 16'h0000, 1, 1, 0, 16'h5555, 1, 0};
        tbl[8]  = '{0, 16'h0000, 0, 1, 0, 16'hAAAA, 0, 0};
        tbl[9]  = '{1, 16'hBEEF, 0, 1, 0, 16'hBEEF, 0, 1};
        tbl[10] = '{0, 16'h0000, 0, 0, 1, 16'hBEEF, 0, 0};
        tbl[11] = '{0, 16'h0000, 0, 0, 0, 16'hBEEF, 0, 0};
        tbl[12] = '{1, 16'h1111, 1, 0, 0, 16'h1111, 1, 0};
        tbl[13] = '{1, 16'h3333, 1, 1, 0, 16'h3333, 1, 0};
        tbl[14] = '{0, 16'h0000, 0, 1, 0, 16'h1111, 0, 0};
        tbl[15] = '{0, 16'h0000, 0, 1, 1, 16'h1111, 0, 1};
        tbl[16] = '{0, 16'h0000, 0, 0, 1, 16'h1111, 0, 0};

        #12;
        chk("init_acc", 32'(bus.acc_data), 0);
        chk("init_lvl", 32'(bus.stk_level), 0);
        chk("init_empty", 32'(bus.stk_empty), 1);
        chk("init_full", 32'(bus.stk_full), 0);
        chk("init_err", 32'(bus.stk_err), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rw, tbl[i].din, tbl[i].push,
                  tbl[i].pop, tbl[i].clr);
            chk($sformatf("vec%0d_acc", i),
                32'(bus.acc_data), 32'(tbl[i].e_acc));
            chk($sformatf("vec%0d_lvl", i),
                32'(bus.stk_level), 32'(tbl[i].e_lvl));
            chk($sformatf("vec%0d_full", i),
                32'(bus.stk_full), 32'(tbl[i].e_lvl == 4'd8));
            chk($sformatf("vec%0d_empty", i),
                32'(bus.stk_empty), 32'(tbl[i].e_lvl == 4'd0));
            chk($sformatf("vec%0d_err", i),
                32'(bus.stk_err), 32'(tbl[i].e_err & ERR_EN));
        end

        // fill to full, overflow, then drain in LIFO order
        do_reset();
        for (int k = 1; k <= DEPTH; k++) begin
            drive(1, 16'(k), 0, 0, 0);
            drive(0, 0, 1, 0, 0);
        end
        chk_model("fill");
        chk("fill_full", 32'(bus.stk_full), 1);
        drive(0, 0, 1, 0, 0);
        chk_model("ovf");
        chk("ovf_lvl", 32'(bus.stk_level), DEPTH);
        chk("ovf_err", 32'(bus.stk_err), 32'(ERR_EN));
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 0, 0, 1, 0);
            chk($sformatf("drain%0d_acc", k),
                32'(bus.acc_data), DEPTH - k);
        end
        chk_model("drain");
        drive(1, 16'h7777, 1, 1, 1);
        chk_model("xchg_empty");

        // asynchronous reset in the middle of a sequence
        do_reset();
        for (int k = 0; k < 3; k++)
            drive(1, 16'(16'hA0 + k), 1, 0, 0);
        chk("mid_lvl", 32'(bus.stk_level), 3);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst_acc", 32'(bus.acc_data), 0);
        chk("arst_lvl", 32'(bus.stk_level), 0);
        chk("arst_empty", 32'(bus.stk_empty), 1);
        chk("arst_full", 32'(bus.stk_full), 0);
        chk("arst_err", 32'(bus.stk_err), 0);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0);
        chk_model("post_rst_pop");
        chk("post_rst_err", 32'(bus.stk_err), 32'(ERR_EN));

        // randomized traffic, push-biased first then pop-biased
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic pu, po, rw, clr;
            int   bias;
            bias = (c % 200 < 100) ? 6 : 3;
            pu   = ($urandom_range(0, 9) < bias);
            po   = ($urandom_range(0, 9) < 9 - bias);
            rw   = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 7) == 0);
            drive(rw, 16'($urandom), pu, po, clr);
            chk_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
